disp_msg_sched: RTL and testbench
=================================

// Module: disp_msg_sched
// PURPOSE
// Time-multiplexes the irrigation panel's single 4-digit 7-segment display between status messages M0..M7.
// Status logic raises one request flag per message; this block rotates round-robin through active requests.
// M7 (critical) pre-empts rotation while requested. Scans digits with anti-ghost blanking; owns seg and digit enables.
// PARAMETERS
// SCAN_DIV     50000  clocks per digit slot (>=2)
// BLANK_CYC    8      clocks at start of each slot with all digits off (1..SCAN_DIV-1)
// HOLD_FRAMES  200    frames a message is held before rotation (>=1); frame = 4 slots
// PORTS
// clk        in   1  system clock
// rst_n      in   1  asynchronous active-low reset
// msg_req    in   8  bit k = message Mk requested (level, synchronous to clk)
// seg        out  7  segments {g,f,e,d,c,b,a}, active-low (1 = off)
// dig        out  4  digit enables rd1..rd4, active-low (1 = off)
// cur_id     out  3  message currently shown
// cur_valid  out  1  1 = a message is shown, 0 = display blanked
// msg_chg    out  1  one-clock pulse when cur_id/cur_valid changes
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low. On rst_n=0, immediately: seg=7'h7F, dig=4'hF,
//   cur_id=0, cur_valid=0, msg_chg=0, prescaler=0, dig_idx=0, hold=0. Reset mid-frame aborts with no residue.
// - Prescaler counts 0..SCAN_DIV-1; slot_end when it is SCAN_DIV-1. dig_idx 0..3 increments at slot_end, wraps 3->0.
// - frame_tick = slot_end with dig_idx==3. Message selection changes ONLY at frame_tick (no torn frames).
// - All outputs registered (1-clock latency from internal state).
// - Prescaler < BLANK_CYC: dig=4'hF. Otherwise dig = ~(1<<dig_idx) if cur_valid, else 4'hF.
// - seg = glyph(cur_id, dig_idx) when digit driven, else 7'h7F.
// - Selection at each frame_tick, first matching rule wins:
//   1. msg_req[7]=1 -> cur_id=7, valid=1, hold=0 (no rotation while held).
//   2. msg_req==0 -> cur_valid=0, hold=0 (blank).
//   3. !cur_valid or msg_req[cur_id]==0 -> next requested id, hold=0.
//   4. hold==HOLD_FRAMES-1 -> next requested id, hold=0 (may reselect cur_id if it is the only request).
//   5. else hold+1.
// - Next requested id: round-robin scan cur_id+1, +2, ... mod 8, cur_id checked last; first set bit wins.
// - msg_chg=1 for the clock after a frame_tick where cur_id or cur_valid changed; reselecting same id: no pulse.
// - msg_req toggling mid-frame has no visible effect until the next frame_tick.
// - Widths: prescaler $clog2(SCAN_DIV); hold $clog2(HOLD_FRAMES+1); no counter overflows.
// STRUCTURE
// - Shared include disp_defs.vh: SEG_OFF=7'h7F, DIG_OFF=4'hF, MSG_CRIT=3'd7, glyph constants (M, digits 0-9, blank).
// - Sub-module msg_glyph_rom: combinational (id[2:0], pos[1:0]) -> seg[6:0]; Mk renders "M k  " left-aligned,
//   with unused digits as blank glyphs. Scheduler, scan counters and output registers live in disp_msg_sched.
// TESTING (bench params SCAN_DIV=4, BLANK_CYC=1, HOLD_FRAMES=2; frame = 16 clk)
// 1. msg_req=8'h04 from reset -> cur_valid=1, cur_id=2 after first frame_tick, one msg_chg pulse;
//    dig per slot 1111,1110,1110,1110 then 1111,1101x3, 1111,1011x3, 1111,0111x3; seg = ROM glyphs.
// 2. msg_req=8'h0A held -> cur_id 1 for 32 clk, 3 for 32 clk, back to 1; msg_chg pulses at each switch.
// 3. Showing id 1 (req 8'h0A), req[7] raised mid-frame -> still 1 until frame_tick, then 7 and held while
//    bit 7 stays high; after release, the next frame_tick selects 1 (scan wraps 0,1 from 7).
// 4. Current request dropped mid-hold (8'h0A -> 8'h08 while on 1) -> 3 at next frame_tick;
//    then msg_req=0 -> cur_valid=0, dig=4'hF, seg=7'h7F from next frame.
// 5. Only msg_req=8'h01 for 5 frames -> cur_id stays 0, exactly one msg_chg pulse total.
// 6. rst_n pulsed low mid-slot -> seg/dig/cur_valid at reset values same cycle; after release, cur_id=0
//    and the selection restarts at the first frame_tick.

Source files
------------

// File: rtl/disp_msg_sched_pkg.sv
// disp_msg_sched_pkg: display constants, glyph table and round-robin helper
package disp_msg_sched_pkg;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] DIG_OFF = 4'hF;
  localparam logic [2:0] MSG_CRIT = 3'd7;
  localparam logic [6:0] G_M = 7'h48;
  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DIGIT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  // Scan cur+1 .. cur+8 (cur last); nearest set bit wins.
  function automatic logic [2:0] next_req(input logic [7:0] req, input logic [2:0] cur);
    logic [2:0] n;
    n = cur;
    for (int i = 8; i >= 1; i--)
      if (req[3'(cur + 3'(i))]) n = 3'(cur + 3'(i));
    return n;
  endfunction
endpackage

// File: rtl/disp_msg_sched_if.sv
// disp_msg_sched_if: request flags in, display drive and status out
interface disp_msg_sched_if;
  logic [7:0] msg_req;
  logic [6:0] seg;
  logic [3:0] dig;
  logic [2:0] cur_id;
  logic cur_valid;
  logic msg_chg;
  modport master(output msg_req, input seg, dig, cur_id, cur_valid, msg_chg);
  modport slave(input msg_req, output seg, dig, cur_id, cur_valid, msg_chg);
endinterface

// File: rtl/disp_msg_sched_rom.sv
// msg_glyph_rom: renders "Mk  " left-aligned, one digit position at a time
module msg_glyph_rom
  import disp_msg_sched_pkg::*;
(
  input  logic [2:0] id,
  input  logic [1:0] pos,
  output logic [6:0] seg
);
  assign seg = pos == 2'd0 ? G_M : pos == 2'd1 ? G_DIGIT[{1'b0, id}] : G_BLANK;
endmodule

// File: rtl/disp_msg_sched.sv
// disp_msg_sched: round-robin message scheduler with critical pre-emption and blanked digit scan
module disp_msg_sched
  import disp_msg_sched_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYC = 8,
  parameter int HOLD_FRAMES = 200
) (
  input logic clk,
  input logic rst_n,
  disp_msg_sched_if.slave bus
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  logic [PW-1:0] pre;
  logic [1:0] idx;
  logic [HW-1:0] hold, hold_n;
  logic [2:0] cur_id, id_n;
  logic cur_valid, val_n;
  logic slot_end, frame_tick, lit;
  logic [6:0] glyph;
  assign slot_end = pre == PW'(SCAN_DIV - 1);
  assign frame_tick = slot_end && idx == 2'd3;
  assign lit = pre >= PW'(BLANK_CYC) && cur_valid;
  assign bus.cur_id = cur_id;
  assign bus.cur_valid = cur_valid;
  msg_glyph_rom u_rom (.id(cur_id), .pos(idx), .seg(glyph));
  // Selection only moves on frame boundaries so a frame never mixes two messages.
  always_comb begin
    id_n = cur_id;
    val_n = cur_valid;
    hold_n = hold;
    if (frame_tick) begin
      if (bus.msg_req[MSG_CRIT]) begin
        id_n = MSG_CRIT;
        val_n = 1'b1;
        hold_n = '0;
      end else if (bus.msg_req == 8'd0) begin
        val_n = 1'b0;
        hold_n = '0;
      end else if (!cur_valid || !bus.msg_req[cur_id] || hold == HW'(HOLD_FRAMES - 1)) begin
        id_n = next_req(bus.msg_req, cur_id);
        val_n = 1'b1;
        hold_n = '0;
      end else
        hold_n = hold + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
      hold <= '0;
      cur_id <= '0;
      cur_valid <= 1'b0;
      bus.seg <= SEG_OFF;
      bus.dig <= DIG_OFF;
      bus.msg_chg <= 1'b0;
    end else begin
      pre <= slot_end ? '0 : pre + 1'b1;
      idx <= idx + 2'(slot_end);
      hold <= hold_n;
      cur_id <= id_n;
      cur_valid <= val_n;
      bus.seg <= lit ? glyph : SEG_OFF;
      bus.dig <= lit ? ~(4'b1 << idx) : DIG_OFF;
      bus.msg_chg <= id_n != cur_id || val_n != cur_valid;
    end
endmodule

// File: tb/tb_disp_msg_sched.sv
// tb_disp_msg_sched: random request patterns checked cycle-by-cycle against a frame-level model
module tb_disp_msg_sched;
  localparam int SD = 4, BL = 1, HF = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_pass = 0;
  int c;
  int m_hold;
  logic [2:0] m_id;
  bit m_val;
  logic [6:0] e_seg;
  logic [3:0] e_dig;
  bit e_chg;
  disp_msg_sched_if bus();
  disp_msg_sched #(.SCAN_DIV(SD), .BLANK_CYC(BL), .HOLD_FRAMES(HF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask
  function automatic logic [6:0] glyph_ref(input logic [2:0] id, input int pos);
    logic [6:0] hi [10];
    hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return pos == 0 ? ~7'h37 : pos == 1 ? ~hi[id] : 7'h7F;
  endfunction
  function automatic logic [2:0] rr(input logic [7:0] req, input logic [2:0] cur);
    for (int i = 1; i <= 8; i++)
      if (req[(cur + i) % 8]) return 3'((cur + i) % 8);
    return cur;
  endfunction
  task automatic model_reset();
    c = 0;
    m_hold = 0;
    m_id = 3'd0;
    m_val = 1'b0;
    e_seg = 7'h7F;
    e_dig = 4'hF;
    e_chg = 1'b0;
  endtask
  task automatic check_all();
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dig", 32'(bus.dig), 32'(e_dig));
    check("cur_id", 32'(bus.cur_id), 32'(m_id));
    check("cur_valid", 32'(bus.cur_valid), 32'(m_val));
    check("msg_chg", 32'(bus.msg_chg), 32'(e_chg));
  endtask
  task automatic cycle(input logic [7:0] req);
    int pos, slot;
    bit lit;
    logic [2:0] nid;
    bit nval;
    bus.msg_req = req;
    pos = c % SD;
    slot = (c / SD) % 4;
    lit = pos >= BL && m_val;
    e_dig = lit ? ~(4'b1 << slot) : 4'hF;
    e_seg = lit ? glyph_ref(m_id, slot) : 7'h7F;
    e_chg = 1'b0;
    if (pos == SD - 1 && slot == 3) begin
      nid = m_id;
      nval = m_val;
      if (req[7]) begin nid = 3'd7; nval = 1'b1; m_hold = 0; end
      else if (req == 8'd0) begin nval = 1'b0; m_hold = 0; end
      else if (!m_val || !req[m_id] || m_hold == HF - 1) begin nid = rr(req, m_id); nval = 1'b1; m_hold = 0; end
      else m_hold++;
      e_chg = nid != m_id || nval != m_val;
      m_id = nid;
      m_val = nval;
    end
    c++;
    @(negedge clk);
    check_all();
  endtask
  task automatic run(input logic [7:0] req, input int n);
    for (int i = 0; i < n; i++) cycle(req);
  endtask
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #1_000_000 $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] r;
    bus.msg_req = 8'd0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    run(8'h04, 80);
    run(8'h0A, 100);
    run(8'h8A, 40);
    run(8'h0A, 40);
    run(8'h0A, 6);
    run(8'h08, 40);
    run(8'h00, 40);
    run(8'h0A, 10);
    pulse_reset();
    run(8'h01, 80);
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom) & 8'h7F;
        1: r = 8'($urandom);
        2: r = 8'h00;
        default: r = 8'h01 << $urandom_range(0, 7);
      endcase
      for (int j = $urandom_range(1, 50); j > 0; j--)
        cycle($urandom_range(0, 9) == 0 ? 8'($urandom) : r);
      if (k % 13 == 7) pulse_reset();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
